// File: rtl/load_store_unit.sv
// load_store_unit: bridge between the pipeline memory stage and a word-wide dmem.
// Decodes access width from funct3, drives byte-lane write flags and lane-shifted
// store data, and extracts/extends load data. Accesses crossing a word boundary
// are issued as two dmem word phases (PH0 = lower word, PH1 = next word).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata  request fields, latched on accept
//   resp_valid/rdata/error   one-cycle response pulse, rdata/error held
//   mem_address/write_data/enable/write_flag  registered dmem controls
//   mem_read_data            combinational dmem read data
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [29:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_enable,
    output logic [3:0]  mem_write_flag
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned WAW  = 30;

    typedef enum logic [1:0] {IDLE, PH0, PH1, RESP} state_t;

    state_t state, state_n;

    logic            wr_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, lo_q, lo_n;

    logic            req_ready_n, resp_valid_n, resp_error_n, mem_enable_n, accept;
    logic [XLEN-1:0] resp_rdata_n, mem_write_data_n;
    logic [WAW-1:0]  mem_address_n;
    logic [3:0]      mem_write_flag_n;

    // Legal encodings: LB/LH/LW/LBU/LHU for loads, SB/SH/SW for stores.
    function automatic logic is_legal(input logic w, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b100, 3'b101:         is_legal = ~w;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    // Align the two-word window to the byte offset, then sign/zero extend.
    function automatic logic [31:0] extend(input logic [63:0] raw, input logic [1:0] off,
                                           input logic [2:0] f3);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extend = {24'b0, sh[7:0]};
            3'b101:  extend = {16'b0, sh[15:0]};
            default: extend = sh[31:0];
        endcase
    endfunction

    // Request fields come straight from the inputs in IDLE, from the latches afterwards.
    logic            src_write;
    logic [2:0]      src_f3;
    logic [XLEN-1:0] src_addr, src_wdata;
    logic [1:0]      off;
    logic [2:0]      size;
    logic [3:0]      base;
    logic [7:0]      mask8;
    logic [63:0]     wide;
    logic            split;

    assign src_write = (state == IDLE) ? req_write  : wr_q;
    assign src_f3    = (state == IDLE) ? req_funct3 : f3_q;
    assign src_addr  = (state == IDLE) ? req_addr   : addr_q;
    assign src_wdata = (state == IDLE) ? req_wdata  : wdata_q;
    assign off       = src_addr[1:0];

    // Width decode and lane placement for both phases.
    always_comb begin
        size = 3'd4;
        base = 4'b1111;
        case (src_f3[1:0])
            2'b00: begin size = 3'd1; base = 4'b0001; end
            2'b01: begin size = 3'd2; base = 4'b0011; end
            default: ;
        endcase
    end

    assign mask8 = 8'(base) << off;
    assign wide  = 64'(src_wdata) << {off, 3'b000};
    assign split = (3'(off) + size) > 3'd4;
    assign accept = (state == IDLE) && req_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n          = state;
        resp_valid_n     = 1'b0;
        resp_rdata_n     = resp_rdata;
        resp_error_n     = resp_error;
        mem_address_n    = '0;
        mem_write_data_n = '0;
        mem_enable_n     = 1'b0;
        mem_write_flag_n = '0;
        lo_n             = lo_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_legal(req_write, req_funct3)) begin
                        state_n          = PH0;
                        mem_address_n    = src_addr[31:2];
                        mem_write_data_n = wide[31:0];
                        mem_enable_n     = src_write;
                        mem_write_flag_n = src_write ? mask8[3:0] : 4'b0000;
                    end else begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                        resp_rdata_n = '0;
                    end
                end
            end
            PH0: begin
                lo_n = mem_read_data;
                if (split) begin
                    state_n          = PH1;
                    mem_address_n    = addr_q[31:2] + WAW'(1);
                    mem_write_data_n = wide[63:32];
                    mem_enable_n     = wr_q;
                    mem_write_flag_n = wr_q ? mask8[7:4] : 4'b0000;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_error_n = 1'b0;
                    resp_rdata_n = wr_q ? '0 : extend({32'b0, mem_read_data}, addr_q[1:0], f3_q);
                end
            end
            PH1: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_error_n = 1'b0;
                resp_rdata_n = wr_q ? '0 : extend({mem_read_data, lo_q}, addr_q[1:0], f3_q);
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

    // Output and request-latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_enable     <= 1'b0;
            mem_write_flag <= '0;
            wr_q           <= 1'b0;
            f3_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            lo_q           <= '0;
        end else begin
            req_ready      <= req_ready_n;
            resp_valid     <= resp_valid_n;
            resp_rdata     <= resp_rdata_n;
            resp_error     <= resp_error_n;
            mem_address    <= mem_address_n;
            mem_write_data <= mem_write_data_n;
            mem_enable     <= mem_enable_n;
            mem_write_flag <= mem_write_flag_n;
            lo_q           <= lo_n;
            if (accept) begin
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// Emulates a level-sensitive dmem (written mid-cycle while mem_enable is high)
// and predicts results from a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk, rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [29:0] mem_address;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_enable;
    logic [3:0]  mem_write_flag;

    int checks = 0;
    int failures = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_enable(mem_enable),
        .mem_write_flag(mem_write_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem emulation: write while enabled, then present read data for the rest of the cycle.
    logic [31:0] dmem [logic [29:0]];
    always @(negedge clk) begin
        logic [31:0] w;
        if (mem_enable) begin
            w = dmem.exists(mem_address) ? dmem[mem_address] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (mem_write_flag[i]) w[8*i +: 8] = mem_write_data[8*i +: 8];
            dmem[mem_address] = w;
        end
        mem_read_data = dmem.exists(mem_address) ? dmem[mem_address] : 32'h0;
    end

    // Reference model: byte memory plus RV32I access rules.
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_legal(input logic w, input logic [2:0] f3);
        if (w) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic bit crosses(input logic [31:0] a, input logic [2:0] f3);
        return (int'(a[1:0]) + acc_size(f3)) > 4;
    endfunction

    function automatic int exp_lat(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (!ref_legal(w, f3)) return 1;
        return crosses(a, f3) ? 3 : 2;
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        for (int i = 0; i < acc_size(f3); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < acc_size(f3); i++) v[8*i +: 8] = rb(a + 32'(i));
        if (f3 == 3'd0) return {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) return {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Lanes of word (a[31:2]+p) that fall inside [a, a+size).
    function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [2:0] f3, input int p);
        logic [29:0] wa = a[31:2] + 30'(p);
        logic [31:0] d;
        logic [3:0] f = 4'b0;
        for (int i = 0; i < 4; i++) begin
            d = {wa, 2'(i)} - a;
            if (d < 32'(acc_size(f3))) f[i] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [31:0] ref_lane_data(input logic [31:0] a, input logic [2:0] f3,
                                                  input int p, input logic [31:0] wd);
        logic [29:0] wa = a[31:2] + 30'(p);
        logic [31:0] d;
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            d = {wa, 2'(i)} - a;
            if (d < 32'(acc_size(f3))) r[8*i +: 8] = wd[8*d[1:0] +: 8];
        end
        return r;
    endfunction

    // Per-transaction observations.
    logic [29:0] ph_addr [4];
    logic [31:0] ph_data [4];
    logic [3:0]  ph_flag [4];
    int          n_ph, n_en;
    logic        ready_at_start, ready_while_busy;

    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] rd,
                           output logic er);
        @(negedge clk);
        ready_at_start = req_ready;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        // Garbage with valid held high while busy must be ignored.
        req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; rd = 'x; er = 1'bx; n_ph = 0; n_en = 0; ready_while_busy = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_error;
                req_valid = 1'b0;
                break;
            end
            if (req_ready) ready_while_busy = 1'b1;
            if (n_ph < 4) begin
                ph_addr[n_ph] = mem_address; ph_data[n_ph] = mem_write_data;
                ph_flag[n_ph] = mem_write_flag; n_ph++;
            end
            if (mem_enable) n_en++;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #12;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", resp_valid, resp_error); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if ({mem_enable, mem_write_flag, mem_address, mem_write_data} !== 67'h0) begin failures++; $display("FAIL reset_mem got en=%b fl=%b a=%h d=%h exp=0", mem_enable, mem_write_flag, mem_address, mem_write_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er);
        ref_store(32'h100, 3'b010, 32'hDEADBEEF);
        checks++; if (ph_addr[0] !== 30'h40 || ph_flag[0] !== 4'b1111 || ph_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_ph0 got a=%h f=%b d=%h exp a=40 f=1111 d=deadbeef", ph_addr[0], ph_flag[0], ph_data[0]); end
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sw_resp got lat=%0d err=%b rd=%h exp 2 0 0", lat, er, rd); end
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
        checks++; if (lat !== 2 || er !== 1'b0 || n_en !== 0) begin failures++; $display("FAIL lw_lat got lat=%0d err=%b en=%0d exp 2 0 0", lat, er, n_en); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b000, 32'h101, 32'h80, lat, rd, er);
        ref_store(32'h101, 3'b000, 32'h80);
        checks++; if (ph_flag[0] !== 4'b0010 || ph_data[0] !== 32'h00008000) begin failures++; $display("FAIL sb_lane got f=%b d=%h exp f=0010 d=00008000", ph_flag[0], ph_data[0]); end
        run_req(1'b0, 3'b000, 32'h101, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", rd); end
        run_req(1'b0, 3'b100, 32'h101, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", rd); end
    endtask

    task automatic test_split_half();
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b001, 32'h203, 32'hA55A, lat, rd, er);
        ref_store(32'h203, 3'b001, 32'hA55A);
        checks++; if (ph_addr[0] !== 30'h80 || ph_flag[0] !== 4'b1000 || ph_addr[1] !== 30'h81 || ph_flag[1] !== 4'b0001) begin failures++; $display("FAIL sh_split_phases got %h/%b %h/%b exp 80/1000 81/0001", ph_addr[0], ph_flag[0], ph_addr[1], ph_flag[1]); end
        checks++; if (lat !== 3 || n_en !== 2) begin failures++; $display("FAIL sh_split_lat got lat=%0d en=%0d exp 3 2", lat, n_en); end
        run_req(1'b0, 3'b101, 32'h203, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0000A55A || lat !== 3) begin failures++; $display("FAIL lhu_split got rd=%h lat=%0d exp 0000a55a 3", rd, lat); end
        run_req(1'b0, 3'b001, 32'h203, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFFA55A || lat !== 3) begin failures++; $display("FAIL lh_split got rd=%h lat=%0d exp ffffa55a 3", rd, lat); end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic er;
        logic [3:0] cases [4] = '{4'b0011, 4'b1100, 4'b0110, 4'b1111};
        for (int k = 0; k < 4; k++) begin
            run_req(cases[k][3], cases[k][2:0], 32'h100, 32'h12345678, lat, rd, er);
            checks++; if (er !== 1'b1 || rd !== 32'h0 || n_en !== 0 || lat !== 1) begin failures++; $display("FAIL illegal_%0d got err=%b rd=%h en=%0d lat=%0d exp 1 0 0 1", k, er, rd, n_en, lat); end
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b010, 32'hFFFFFFFC, 32'hA1B2C3D4, lat, rd, er);
        ref_store(32'hFFFFFFFC, 3'b010, 32'hA1B2C3D4);
        run_req(1'b1, 3'b010, 32'h0, 32'h55667788, lat, rd, er);
        ref_store(32'h0, 3'b010, 32'h55667788);
        run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, rd, er);
        checks++; if (ph_addr[0] !== 30'h3FFFFFFF || ph_addr[1] !== 30'h0) begin failures++; $display("FAIL wrap_addr got %h %h exp 3fffffff 0", ph_addr[0], ph_addr[1]); end
        checks++; if (rd !== 32'h7788A1B2 || lat !== 3) begin failures++; $display("FAIL wrap_rdata got rd=%h lat=%0d exp 7788a1b2 3", rd, lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; logic saw;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3FE; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_enable !== 1'b1 || mem_address !== 30'hFF || mem_write_flag !== 4'b1100) begin failures++; $display("FAIL mid_ph0 got en=%b a=%h f=%b exp 1 ff 1100", mem_enable, mem_address, mem_write_flag); end
        // PH0 lanes have already been written by the level-sensitive dmem.
        ref_mem[32'h3FE] = 8'h44; ref_mem[32'h3FF] = 8'h33;
        #1 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0 || mem_enable !== 1'b0 || mem_write_flag !== 4'h0 || mem_address !== 30'h0 || mem_write_data !== 32'h0) begin failures++; $display("FAIL mid_reset_outputs got rdy=%b v=%b e=%b rd=%h en=%b f=%b a=%h d=%h exp all reset", req_ready, resp_valid, resp_error, resp_rdata, mem_enable, mem_write_flag, mem_address, mem_write_data); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (resp_valid || !req_ready) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL mid_no_resp got=%b exp=0", saw); end
        run_req(1'b0, 3'b010, 32'h3FC, 32'h0, lat, rd, er);
        checks++; if (rd !== ref_load(32'h3FC, 3'b010) || lat !== 2 || er !== 1'b0) begin failures++; $display("FAIL mid_next_lw got rd=%h lat=%0d exp rd=%h lat=2", rd, lat, ref_load(32'h3FC, 3'b010)); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b001, 32'h302, 32'h00C3B7F0, lat, rd, er);
        ref_store(32'h302, 3'b001, 32'h00C3B7F0);
        run_req(1'b0, 3'b001, 32'h302, 32'h0, lat, rd, er);
        checks++; if (ready_at_start !== 1'b1 || rd !== 32'hFFFFB7F0) begin failures++; $display("FAIL b2b_accept got rdy=%b rd=%h exp 1 ffffb7f0", ready_at_start, rd); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'hFFFFB7F0) begin failures++; $display("FAIL b2b_hold got v=%b rd=%h exp 0 ffffb7f0", resp_valid, resp_rdata); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic er;
        logic w; logic [2:0] f3; logic [31:0] a, d, er_rd;
        logic [3:0] ef; bit ok;
        for (int k = 0; k < 80; k++) begin
            w = 1'($urandom); f3 = 3'($urandom);
            a = 32'h1000 + $urandom_range(0, 31); d = $urandom;
            run_req(w, f3, a, d, lat, rd, er);
            er_rd = (!w && ref_legal(w, f3)) ? ref_load(a, f3) : 32'h0;
            checks++; if (lat !== exp_lat(w, f3, a) || er !== !ref_legal(w, f3) || rd !== er_rd || ready_while_busy !== 1'b0) begin failures++; $display("FAIL rand_resp_%0d w=%b f3=%b a=%h got lat=%0d err=%b rd=%h exp lat=%0d rd=%h", k, w, f3, a, lat, er, rd, exp_lat(w, f3, a), er_rd); end
            ok = (n_en == ((w && ref_legal(w, f3)) ? (crosses(a, f3) ? 2 : 1) : 0));
            if (w && ref_legal(w, f3)) begin
                for (int p = 0; p < lat - 1; p++) begin
                    ef = ref_flags(a, f3, p);
                    if (ph_addr[p] !== a[31:2] + 30'(p) || ph_flag[p] !== ef) ok = 1'b0;
                    for (int i = 0; i < 4; i++)
                        if (ef[i] && ph_data[p][8*i +: 8] !== ref_lane_data(a, f3, p, d)[8*i +: 8]) ok = 1'b0;
                end
                ref_store(a, f3, d);
            end
            checks++; if (!ok) begin failures++; $display("FAIL rand_phase_%0d w=%b f3=%b a=%h d=%h got en=%0d f0=%b f1=%b", k, w, f3, a, d, n_en, ph_flag[0], ph_flag[1]); end
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_split_half();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
